// File: rtl/jtag_pkg.sv
// jtag_pkg: opcode constants, register widths and the decoded-select struct shared by the DR bank.
package jtag_pkg;
  localparam int OP_BYPASS   = -1;
  localparam int OP_SAMPLE   = 1;
  localparam int OP_EXTEST   = 2;
  localparam int OP_INTEST   = 3;
  localparam int OP_CLAMP    = 5;
  localparam int OP_IDCODE   = 7;
  localparam int OP_USERCODE = 8;
  localparam int OP_HIGHZ    = 9;
  localparam int ID_WIDTH    = 32;
  localparam int USER_WIDTH  = 32;
  typedef struct packed {
    logic bypass;
    logic sample;
    logic extest;
    logic intest;
    logic clamp;
    logic highz;
    logic idcode;
    logic usercode;
  } sel_t;
  function automatic logic bsr_sel(input sel_t s);
    return s.sample | s.extest | s.intest;
  endfunction
endpackage

// File: rtl/jtag_bsr_cell.sv
// jtag_bsr_cell: one boundary-scan cell with capture/shift stage and update latch.
module jtag_bsr_cell (
  input  logic tck,
  input  logic rst,
  input  logic capture,
  input  logic shift,
  input  logic update,
  input  logic pi,
  input  logic si,
  output logic so,
  output logic uo
);
  always_ff @(posedge tck)
    if (rst) begin
      so <= 1'b0;
      uo <= 1'b0;
    end else begin
      so <= capture ? pi : shift ? si : so;
      uo <= (update && !capture && !shift) ? so : uo;
    end
endmodule

// File: rtl/jtag_dr_bank.sv
// jtag_dr_bank: JTAG data registers (bypass, IDCODE, BSR) with TDO mux and pad steering.
// Optional USERCODE register is built when JTAG_DR_USERCODE_EN is defined.
module jtag_dr_bank
  import jtag_pkg::*;
#(
  parameter int          IR_WIDTH   = 4,
  parameter int          N_PINS     = 4,
  parameter logic [31:0] ID_VALUE   = 32'h1000_00A1,
  parameter logic [31:0] USER_VALUE = 32'h0000_00A1
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TLR,
  input  logic                TDI,
  input  logic [IR_WIDTH-1:0] LATCH_IR,
  input  logic                CAPTURE_DR,
  input  logic                SHIFT_DR,
  input  logic                UPDATE_DR,
  input  logic [N_PINS-1:0]   PIN_IN,
  input  logic [N_PINS-1:0]   CORE_OUT,
  output logic [N_PINS-1:0]   PIN_OUT,
  output logic                PIN_OE,
  output logic [N_PINS-1:0]   CORE_IN,
  output logic                TDO,
  output logic                TDO_EN
);
  sel_t                  sel;
  logic                  rst;
  logic                  byp_on;
  logic                  bsr_on;
  logic                  bypass_q;
  logic                  usr_bit;
  logic                  tdo_d;
  logic [ID_WIDTH-1:0]   id_q;
  logic [2*N_PINS-1:0]   bsr_q;
  logic [2*N_PINS-1:0]   upd_q;
  logic [2*N_PINS-1:0]   bsr_si;
  logic [2*N_PINS-1:0]   bsr_pi;
  always_comb begin
    sel          = '0;
    sel.sample   = LATCH_IR == IR_WIDTH'(OP_SAMPLE);
    sel.extest   = LATCH_IR == IR_WIDTH'(OP_EXTEST);
    sel.intest   = LATCH_IR == IR_WIDTH'(OP_INTEST);
    sel.clamp    = LATCH_IR == IR_WIDTH'(OP_CLAMP);
    sel.highz    = LATCH_IR == IR_WIDTH'(OP_HIGHZ);
    sel.idcode   = LATCH_IR == IR_WIDTH'(OP_IDCODE);
`ifdef JTAG_DR_USERCODE_EN
    sel.usercode = LATCH_IR == IR_WIDTH'(OP_USERCODE);
`endif
    // anything not claimed above, including OP_BYPASS itself, falls back to bypass
    sel.bypass   = !(sel.sample | sel.extest | sel.intest | sel.clamp | sel.highz | sel.idcode | sel.usercode);
  end
  assign rst    = !TRST || TLR;
  assign byp_on = sel.bypass | sel.clamp | sel.highz;
  assign bsr_on = bsr_sel(sel);
  always_ff @(posedge TCK)
    if (rst) bypass_q <= 1'b0;
    else if (byp_on) bypass_q <= CAPTURE_DR ? 1'b0 : SHIFT_DR ? TDI : bypass_q;
  always_ff @(posedge TCK)
    if (rst) id_q <= ID_VALUE;
    else if (sel.idcode) id_q <= CAPTURE_DR ? ID_VALUE : SHIFT_DR ? {TDI, id_q[ID_WIDTH-1:1]} : id_q;
`ifdef JTAG_DR_USERCODE_EN
  logic [USER_WIDTH-1:0] usr_q;
  always_ff @(posedge TCK)
    if (rst) usr_q <= USER_VALUE;
    else if (sel.usercode) usr_q <= CAPTURE_DR ? USER_VALUE : SHIFT_DR ? {TDI, usr_q[USER_WIDTH-1:1]} : usr_q;
  assign usr_bit = usr_q[0];
`else
  // never selected in this build; tied to a constant so the mux shape stays the same
  assign usr_bit = USER_VALUE[0];
`endif
  assign bsr_pi = {CORE_OUT, PIN_IN};
  assign bsr_si = {TDI, bsr_q[2*N_PINS-1:1]};
  for (genvar i = 0; i < 2*N_PINS; i++) begin : g_cell
    jtag_bsr_cell u_cell (
      .tck    (TCK),
      .rst    (rst),
      .capture(CAPTURE_DR && bsr_on),
      .shift  (SHIFT_DR && bsr_on),
      .update (UPDATE_DR && bsr_on),
      .pi     (bsr_pi[i]),
      .si     (bsr_si[i]),
      .so     (bsr_q[i]),
      .uo     (upd_q[i])
    );
  end
  assign tdo_d = bsr_on ? bsr_q[0] : sel.idcode ? id_q[0] : sel.usercode ? usr_bit : bypass_q;
  always_ff @(negedge TCK)
    if (!TRST) begin
      TDO    <= 1'b0;
      TDO_EN <= 1'b0;
    end else begin
      TDO    <= tdo_d;
      TDO_EN <= SHIFT_DR;
    end
  assign PIN_OUT = (sel.extest || sel.clamp) ? upd_q[2*N_PINS-1:N_PINS] : CORE_OUT;
  assign PIN_OE  = !sel.highz;
  assign CORE_IN = sel.intest ? upd_q[N_PINS-1:0] : PIN_IN;
endmodule

// File: tb/tb_jtag_dr_bank.sv
// tb_jtag_dr_bank: directed scans against a behavioural model plus literal pins.
module tb_jtag_dr_bank;
  logic       TCK = 1'b0;
  logic       TRST, TLR, TDI, CAPTURE_DR, SHIFT_DR, UPDATE_DR;
  logic [3:0] LATCH_IR, PIN_IN, CORE_OUT, PIN_OUT, CORE_IN;
  logic       PIN_OE, TDO, TDO_EN;
  int         total = 0;
  int         bad = 0;
  logic       en = 1'b0;
  logic        m_byp, m_tdo, m_en;
  logic [31:0] m_id, m_usr, q;
  logic [7:0]  m_sh, m_up;

  jtag_dr_bank dut (
    .TCK(TCK), .TRST(TRST), .TLR(TLR), .TDI(TDI), .LATCH_IR(LATCH_IR),
    .CAPTURE_DR(CAPTURE_DR), .SHIFT_DR(SHIFT_DR), .UPDATE_DR(UPDATE_DR),
    .PIN_IN(PIN_IN), .CORE_OUT(CORE_OUT), .PIN_OUT(PIN_OUT), .PIN_OE(PIN_OE),
    .CORE_IN(CORE_IN), .TDO(TDO), .TDO_EN(TDO_EN)
  );

  always #5 TCK = ~TCK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // instruction class: opcode value for known ones, 0 for anything treated as bypass
  function automatic int kind(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd3, 4'd5, 4'd7, 4'd9: return int'(op);
`ifdef JTAG_DR_USERCODE_EN
      4'd8: return 8;
`endif
      default: return 0;
    endcase
  endfunction

  always @(posedge TCK) begin
    int k;
    k = kind(LATCH_IR);
    if (!TRST || TLR) begin
      m_byp = 1'b0; m_id = 32'h1000_00A1; m_usr = 32'h0000_00A1; m_sh = '0; m_up = '0;
    end else if (CAPTURE_DR) begin
      if (k == 0 || k == 5 || k == 9) m_byp = 1'b0;
      if (k == 7) m_id = 32'h1000_00A1;
      if (k == 8) m_usr = 32'h0000_00A1;
      if (k >= 1 && k <= 3) m_sh = {CORE_OUT, PIN_IN};
    end else if (SHIFT_DR) begin
      if (k == 0 || k == 5 || k == 9) m_byp = TDI;
      if (k == 7) m_id = (m_id >> 1) | (32'(TDI) << 31);
      if (k == 8) m_usr = (m_usr >> 1) | (32'(TDI) << 31);
      if (k >= 1 && k <= 3) m_sh = (m_sh >> 1) | (8'(TDI) << 7);
    end else if (UPDATE_DR && k >= 1 && k <= 3) m_up = m_sh;
  end

  always @(negedge TCK) begin
    int k;
    k = kind(LATCH_IR);
    m_tdo = !TRST ? 1'b0 : (k >= 1 && k <= 3) ? m_sh[0] : k == 7 ? m_id[0] : k == 8 ? m_usr[0] : m_byp;
    m_en = TRST & SHIFT_DR;
  end

  always @(negedge TCK) begin
    int k;
    #3;
    if (en) begin
      k = kind(LATCH_IR);
      chk("tdo", 32'(TDO), 32'(m_tdo));
      chk("tdo_en", 32'(TDO_EN), 32'(m_en));
      chk("pin_out", 32'(PIN_OUT), 32'((k == 2 || k == 5) ? m_up[7:4] : CORE_OUT));
      chk("pin_oe", 32'(PIN_OE), 32'(k != 9));
      chk("core_in", 32'(CORE_IN), 32'((k == 3) ? m_up[3:0] : PIN_IN));
    end
  end

  task automatic cyc(input logic c, input logic s, input logic u, input logic d);
    CAPTURE_DR = c; SHIFT_DR = s; UPDATE_DR = u; TDI = d;
    @(negedge TCK);
    #1;
  endtask

  task automatic scan(input logic [3:0] op, input logic [31:0] d, input int n, output logic [31:0] r);
    LATCH_IR = op;
    r = '0;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      r[i] = TDO;
      cyc(0, 1, 0, d[i]);
    end
    cyc(0, 0, 1, 0);
  endtask

  initial begin
    TRST = 1'b0; TLR = 1'b0; TDI = 1'b0; CAPTURE_DR = 1'b0; SHIFT_DR = 1'b0; UPDATE_DR = 1'b0;
    LATCH_IR = 4'hF; PIN_IN = 4'h6; CORE_OUT = 4'h5;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    TRST = 1'b1;
    en = 1'b1;
    chk("reset_tdo", 32'(TDO), 32'd0);
    chk("reset_tdo_en", 32'(TDO_EN), 32'd0);
    LATCH_IR = 4'h2; #1;
    chk("reset_upd", 32'(PIN_OUT), 32'h0);
    scan(4'h7, 32'h0, 32, q);
    chk("idcode_first_bit", 32'(q[0]), 32'd1);
    chk("idcode_word", q, 32'h1000_00A1);
    scan(4'hF, 32'h5, 4, q);
    chk("bypass_seq", q, 32'hA);
    scan(4'hC, 32'h5, 4, q);
    chk("undef_seq", q, 32'hA);
`ifdef JTAG_DR_USERCODE_EN
    scan(4'h8, 32'h0, 32, q);
    chk("usercode_word", q, 32'h0000_00A1);
`else
    scan(4'h8, 32'h5, 4, q);
    chk("usercode_as_bypass", q, 32'hA);
`endif
    scan(4'h2, 32'hA5, 8, q);
    chk("extest_capture", q, 32'h56);
    chk("extest_pin_out", 32'(PIN_OUT), 32'hA);
    CORE_OUT = 4'h9;
    cyc(0, 0, 0, 0);
    chk("extest_core_ignored", 32'(PIN_OUT), 32'hA);
    scan(4'h9, 32'h5, 4, q);
    chk("highz_bypass_seq", q, 32'hA);
    chk("highz_oe", 32'(PIN_OE), 32'd0);
    LATCH_IR = 4'h5; #1;
    chk("clamp_pin_out", 32'(PIN_OUT), 32'hA);
    chk("clamp_oe", 32'(PIN_OE), 32'd1);
    TLR = 1'b1;
    cyc(0, 0, 0, 0);
    TLR = 1'b0;
    chk("tlr_upd_clear", 32'(PIN_OUT), 32'h0);
    chk("tlr_oe", 32'(PIN_OE), 32'd1);
    PIN_IN = 4'h3;
    scan(4'h3, 32'h0C, 8, q);
    chk("intest_core_in", 32'(CORE_IN), 32'hC);
    chk("intest_pin_out", 32'(PIN_OUT), 32'h9);
    CORE_OUT = 4'h5;
    scan(4'h3, 32'h0, 8, q);
    chk("intest_capture", q, 32'h53);
    scan(4'h2, 32'hF0, 8, q);
    chk("extest_f0", 32'(PIN_OUT), 32'hF);
    LATCH_IR = 4'h7;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0);
    TRST = 1'b0;
    cyc(0, 1, 0, 1);
    chk("trst_tdo", 32'(TDO), 32'd0);
    chk("trst_tdo_en", 32'(TDO_EN), 32'd0);
    TRST = 1'b1;
    cyc(0, 0, 0, 0);
    chk("trst_id_reload", 32'(TDO), 32'd1);
    LATCH_IR = 4'h2; #1;
    chk("trst_upd_clear", 32'(PIN_OUT), 32'h0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
